// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//
// Sequences the memory-side datapath for one access at a time: load MAR from
// the bus, (for writes) load MDR from the bus, strobe memory until it answers
// or the wait budget runs out, then report done or err. A single pending slot
// lets a request arrive while an access is in flight, so consecutive accesses
// run back-to-back with no idle cycle between them.
//
// Parameters
//   TIMEOUT    max MEM_WAIT cycles before abort (0..255, 0 = wait forever)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   req        single-cycle access request from the control unit
//   we         access direction, sampled with req (1 = write)
//   mem_ready  memory completion acknowledge, only looked at in MEM_WAIT
//   mar_en     MAR load enable
//   mdr_en     MDR load enable
//   mdr_read   MDR mux select (1 = memory data, 0 = bus)
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//   busy       high whenever the sequencer is not idle
//   cur_we     direction of the access in progress (0 when idle)
//   done       one-cycle completion pulse
//   err        one-cycle timeout pulse
//   overrun    one-cycle pulse when a request is dropped
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic we,
    input  logic mem_ready,
    output logic mar_en,
    output logic mdr_en,
    output logic mdr_read,
    output logic mem_read,
    output logic mem_write,
    output logic busy,
    output logic cur_we,
    output logic done,
    output logic err,
    output logic overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadMar,
        StLoadMdr,
        StMemWait,
        StDone,
        StErr
    } state_t;

    // Counter value on the last permitted wait cycle.
    localparam bit         TimeoutEn = (TIMEOUT != 0);
    localparam logic [7:0] WaitLimit = TimeoutEn ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     state_q, state_d;
    logic       cur_we_q, cur_we_d;
    logic       pend_valid_q, pend_valid_d;
    logic       pend_we_q, pend_we_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Strobes are registered from the next state so they line up with it.
    logic mar_en_q;
    logic mdr_load_q;
    logic mem_read_q;
    logic mem_write_q;
    logic busy_q;
    logic done_q;
    logic err_q;

    always_comb begin
        state_d      = state_q;
        cur_we_d     = cur_we_q;
        pend_valid_d = pend_valid_q;
        pend_we_d    = pend_we_q;
        wait_cnt_d   = wait_cnt_q;
        overrun      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d  = StLoadMar;
                    cur_we_d = we;
                end
            end
            StLoadMar: begin
                state_d    = cur_we_q ? StLoadMdr : StMemWait;
                wait_cnt_d = 8'd0;
            end
            StLoadMdr: begin
                state_d    = StMemWait;
                wait_cnt_d = 8'd0;
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StDone;
                end else if (TimeoutEn && (wait_cnt_q == WaitLimit)) begin
                    state_d = StErr;
                end else if (wait_cnt_q != 8'hff) begin
                    // Saturate: with the timeout disabled the wait is unbounded.
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDone, StErr: begin
                if (pend_valid_q) begin
                    // Consume the slot; a concurrent req refills it.
                    state_d      = StLoadMar;
                    cur_we_d     = pend_we_q;
                    pend_valid_d = req;
                    pend_we_d    = we;
                end else if (req) begin
                    state_d  = StLoadMar;
                    cur_we_d = we;
                end else begin
                    state_d  = StIdle;
                    cur_we_d = 1'b0;
                end
            end
            default: begin
                state_d  = StIdle;
                cur_we_d = 1'b0;
            end
        endcase

        // Requests arriving mid-access go to the pending slot or get dropped.
        if (req && (state_q inside {StLoadMar, StLoadMdr, StMemWait})) begin
            if (pend_valid_q) begin
                overrun = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_we_d    = we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_we_q     <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            wait_cnt_q   <= 8'd0;
            mar_en_q     <= 1'b0;
            mdr_load_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_we_q     <= cur_we_d;
            pend_valid_q <= pend_valid_d;
            pend_we_q    <= pend_we_d;
            wait_cnt_q   <= wait_cnt_d;
            mar_en_q     <= (state_d == StLoadMar);
            mdr_load_q   <= (state_d == StLoadMdr);
            mem_read_q   <= (state_d == StMemWait) && !cur_we_d;
            mem_write_q  <= (state_d == StMemWait) && cur_we_d;
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StDone);
            err_q        <= (state_d == StErr);
        end
    end

    assign mar_en    = mar_en_q;
    // Read capture: MDR loads in the same cycle memory says its data is valid.
    assign mdr_en    = mdr_load_q | (mem_read_q & mem_ready);
    assign mdr_read  = mem_read_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
    assign cur_we    = cur_we_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. A transaction-level model turns each request
// into a schedule (start cycle, wait length, completion cycle) and records the
// expected strobes per cycle plus completion/overrun events in queues; a
// negedge monitor pops and compares whenever the DUT reports an event.
module tb_mem_access_ctrl;

    localparam int TO   = 4;
    localparam int NCYC = 2400;

    logic clk = 1'b0;
    logic reset, req, we, mem_ready;
    logic mar_en, mdr_en, mdr_read, mem_read, mem_write;
    logic busy, cur_we, done, err, overrun;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .mem_ready (mem_ready),
        .mar_en    (mar_en),
        .mdr_en    (mdr_en),
        .mdr_read  (mdr_read),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .busy      (busy),
        .cur_we    (cur_we),
        .done      (done),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_err;
        bit wr;
    } cmp_t;

    // Per-cycle expected {mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, cur_we}.
    bit [6:0] exp_v [NCYC];
    bit       rdy_plan [NCYC];
    bit       in_wait [NCYC];
    cmp_t     cmp_q[$];
    int       ovr_q[$];
    int       comp_q[$];

    int  cyc = -1;
    bit  chk_en = 1'b0;
    bit  noise_en = 1'b0;
    int  ncmp = 0;
    int  nfail = 0;

    function automatic void mark(input int k, input bit [6:0] v);
        if (k >= 0 && k < NCYC) exp_v[k] = exp_v[k] | v;
    endfunction

    // Reference model: capacity is one access in flight plus one pending; an
    // access completing this cycle frees its place for a request this cycle.
    task automatic issue(input bit w, input int wt);
        int r, s, mw, nwait, c;
        r = cyc;
        while (comp_q.size() > 0 && comp_q[0] <= r) void'(comp_q.pop_front());
        if (comp_q.size() >= 2) begin
            ovr_q.push_back(r);
        end else begin
            s = (comp_q.size() > 0) ? comp_q[$] + 1 : r + 1;
            mark(s, {1'b1, 5'b00001, w});
            mw = s + 1;
            if (w) begin
                mark(s + 1, 7'b0100011);
                mw = s + 2;
            end
            nwait = (wt < TO) ? wt + 1 : TO;
            for (int i = 0; i < nwait; i++) begin
                mark(mw + i, w ? 7'b0000111 : 7'b0011010);
                if (mw + i < NCYC) in_wait[mw + i] = 1'b1;
            end
            if (wt < TO) begin
                if (mw + wt < NCYC) rdy_plan[mw + wt] = 1'b1;
                if (!w) mark(mw + wt, 7'b0100000);
            end
            c = mw + nwait;
            mark(c, {5'b00000, 1'b1, w});
            comp_q.push_back(c);
            cmp_q.push_back('{cyc: c, is_err: !(wt < TO), wr: w});
        end
    endtask

    task automatic step(input bit rq, input bit w, input int wt);
        @(posedge clk);
        cyc++;
        #1;
        req = rq;
        we  = rq ? w : 1'($urandom_range(0, 1));
        if (rq && chk_en) issue(w, wt);
        if (chk_en && cyc >= 0 && cyc < NCYC)
            mem_ready = rdy_plan[cyc] |
                        (noise_en && !in_wait[cyc] && ($urandom_range(0, 2) == 0));
        else
            mem_ready = 1'b0;
    endtask

    task automatic check_bits(input string name, input logic [10:0] got,
                              input logic [10:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (chk_en && cyc >= 0 && cyc < NCYC) begin
            ncmp++;
            if ({mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, cur_we} !== exp_v[cyc]) begin
                nfail++;
                $display("FAIL strobes cycle %0d: got %b, required %b", cyc,
                         {mar_en, mdr_en, mdr_read, mem_read, mem_write, busy, cur_we},
                         exp_v[cyc]);
            end
            if (cmp_q.size() > 0 && cmp_q[0].cyc < cyc) begin
                ncmp++;
                nfail++;
                $display("FAIL completion missing: required at cycle %0d, none by %0d",
                         cmp_q[0].cyc, cyc);
                void'(cmp_q.pop_front());
            end
            if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                ncmp++;
                nfail++;
                $display("FAIL overrun missing: required at cycle %0d, none by %0d",
                         ovr_q[0], cyc);
                void'(ovr_q.pop_front());
            end
            if (done || err) begin
                ncmp++;
                if (cmp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL completion unexpected at cycle %0d: done=%b err=%b",
                             cyc, done, err);
                end else begin
                    cmp_t e;
                    e = cmp_q.pop_front();
                    if (e.cyc != cyc || err != e.is_err || done == err || cur_we != e.wr) begin
                        nfail++;
                        $display("FAIL completion: got cycle %0d done=%b err=%b we=%b, required cycle %0d err=%b we=%b",
                                 cyc, done, err, cur_we, e.cyc, e.is_err, e.wr);
                    end
                end
            end
            if (overrun) begin
                ncmp++;
                if (ovr_q.size() == 0) begin
                    nfail++;
                    $display("FAIL overrun unexpected at cycle %0d", cyc);
                end else begin
                    int oc;
                    oc = ovr_q.pop_front();
                    if (oc != cyc) begin
                        nfail++;
                        $display("FAIL overrun: got cycle %0d, required cycle %0d", cyc, oc);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req = 1'b0;
        we = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_bits("reset state", {mar_en, mdr_en, mdr_read, mem_read, mem_write, busy,
                                   cur_we, done, err, overrun, 1'b0}, 11'd0);

        // Reset mid-wait with a write already pending.
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 0);
        @(negedge clk);
        check_bits("in wait before reset", {mem_read, busy, 9'd0}, {2'b11, 9'd0});
        reset = 1'b1;
        step(1'b0, 1'b0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_bits("after mid-wait reset", {mar_en, mdr_en, mdr_read, mem_read, mem_write, busy,
                                            cur_we, done, err, overrun, 1'b0}, 11'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 0);
            @(negedge clk);
            check_bits("quiet after reset", {busy, done, err, mar_en, 7'd0}, 11'd0);
        end

        // Model-checked phase; the first request also shows reset cleared pending.
        cyc = -1;
        chk_en = 1'b1;
        step(1'b1, 1'b0, 0);                          // read, ready immediately
        repeat (5) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 3);                          // write, 3 wait cycles
        repeat (9) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 99);                         // read timeout
        repeat (8) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, TO - 1);                     // ready on limit cycle
        repeat (8) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);                          // queueing: read, write, read
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);
        repeat (12) step(1'b0, 1'b0, 0);

        noise_en = 1'b1;
        for (int i = 0; i < 1800; i++) begin
            step(($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, TO + 2)));
        end
        noise_en = 1'b0;
        for (int i = 0; i < 60 && (cmp_q.size() > 0 || ovr_q.size() > 0); i++)
            step(1'b0, 1'b0, 0);
        repeat (2) step(1'b0, 1'b0, 0);
        @(negedge clk);
        check_bits("events drained", {21'd0, 11'(cmp_q.size() + ovr_q.size())} , 11'd0);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
